neo_pixel_receiver: RTL and testbench

NEO_PIXEL_RECEIVER -- requirements
Module: neo_pixel_receiver

---
 rtl/neo_pixel_receiver.sv | 112 +++++++++++
 tb/tb_neo_pixel_receiver.sv | 139 +++++++++++++
 2 files changed

// File: rtl/neo_pixel_receiver.sv
// neo_pixel_receiver: decodes one 24-bit NeoPixel word per frame and forwards later bits down the chain
// Ports: clock/reset (async, active-high); neo_in raw data; neo_out forwarded data;
//        pixel_data {G,R,B} last latched word; pixel_valid latch pulse; frame_error malformed-frame pulse.
module neo_pixel_receiver #(
  parameter int MIN_HIGH = 5,
  parameter int BIT_THRESH = 26,
  parameter int MAX_HIGH = 60,
  parameter int LATCH_LOW = 2500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        neo_in,
  output logic        neo_out,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic        frame_error
);
  localparam int HW = $clog2(MAX_HIGH + 1);
  localparam int LW = $clog2(LATCH_LOW + 1);
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [HW-1:0] H_MIN = HW'(MIN_HIGH);
  localparam logic [HW-1:0] H_THR = HW'(BIT_THRESH);
  localparam logic [HW-1:0] H_MAX = HW'(MAX_HIGH);
  localparam logic [LW-1:0] L_ONE = LW'(1);
  localparam logic [LW-1:0] L_END = LW'(LATCH_LOW - 1);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, ERROR} state_t;
  state_t state, state_n;
  logic s1, sin, sin_d, fwd, rise, rec, latch, err_in;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [LW-1:0] lcnt, lcnt_n;
  logic [4:0] bit_cnt;
  logic [23:0] sr;
  assign rise = sin & ~sin_d;
  // Counters compare against END-1 so the transition lands on the cycle the count reaches its limit.
  always_comb begin
    state_n = state;
    hcnt_n = hcnt;
    lcnt_n = lcnt;
    rec = 1'b0;
    latch = 1'b0;
    err_in = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_n = HIGH;
        hcnt_n = H_ONE;
      end
      HIGH: if (!sin) begin
        state_n = LOW;
        lcnt_n = L_ONE;
        rec = hcnt >= H_MIN;
      end else begin
        hcnt_n = hcnt < H_MAX ? hcnt + H_ONE : hcnt;
        if (hcnt_n == H_MAX) begin
          state_n = ERROR;
          err_in = 1'b1;
          lcnt_n = '0;
        end
      end
      LOW: if (rise) begin
        state_n = HIGH;
        hcnt_n = H_ONE;
      end else if (lcnt == L_END) begin
        state_n = IDLE;
        latch = 1'b1;
      end else lcnt_n = lcnt + L_ONE;
      default: if (sin) lcnt_n = '0;
        else if (lcnt == L_END) state_n = IDLE;
        else lcnt_n = lcnt + L_ONE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      hcnt <= '0;
      lcnt <= '0;
    end else begin
      state <= state_n;
      hcnt <= hcnt_n;
      lcnt <= lcnt_n;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s1 <= 1'b0;
      sin <= 1'b0;
      sin_d <= 1'b0;
      neo_out <= 1'b0;
      fwd <= 1'b0;
      bit_cnt <= '0;
      sr <= '0;
      pixel_data <= '0;
      pixel_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      s1 <= neo_in;
      sin <= s1;
      sin_d <= sin;
      neo_out <= fwd & sin;
      pixel_valid <= latch && bit_cnt == 5'd24;
      frame_error <= err_in || (latch && bit_cnt != 5'd0 && bit_cnt != 5'd24);
      if (latch && bit_cnt == 5'd24) pixel_data <= sr;
      if (latch || err_in) begin
        bit_cnt <= '0;
        fwd <= 1'b0;
        if (err_in) sr <= '0;
      end else if (rec && bit_cnt != 5'd24) begin
        sr <= {sr[22:0], hcnt > H_THR};
        bit_cnt <= bit_cnt + 5'd1;
        // The 24th bit's own falling edge is already past, so forwarding starts with the next pixel's bits.
        if (bit_cnt == 5'd23) fwd <= 1'b1;
      end
    end
endmodule

// File: tb/tb_neo_pixel_receiver.sv
// tb_neo_pixel_receiver: directed checks of decoding, latching, forwarding, errors and reset abort
module tb_neo_pixel_receiver;
  logic clock = 1'b0, reset = 1'b1, neo_in = 1'b0;
  logic neo_out, pixel_valid, frame_error;
  logic [23:0] pixel_data, pd_prev = '0;
  int errors = 0, checks = 0, cyc = 0;
  int nvalid = 0, nerr = 0, nboth = 0, nbadchg = 0, fe_cyc = 0, first_rise = -1, w = 0;
  int ws[$];
  neo_pixel_receiver dut (
    .clock(clock), .reset(reset), .neo_in(neo_in), .neo_out(neo_out),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .frame_error(frame_error)
  );
  always #10 clock = ~clock;
  always @(posedge clock) cyc++;
  always @(negedge clock) begin
    if (pixel_valid) nvalid++;
    if (frame_error) begin
      nerr++;
      fe_cyc = cyc;
    end
    if (pixel_valid && frame_error) nboth++;
    if (!reset && pixel_data != pd_prev && !pixel_valid) nbadchg++;
    pd_prev = pixel_data;
    if (neo_out) begin
      if (w == 0 && first_rise < 0) first_rise = cyc;
      w++;
    end else if (w > 0) begin
      ws.push_back(w);
      w = 0;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pulse(input int h, input int l);
    neo_in = 1'b1;
    repeat (h) @(negedge clock);
    neo_in = 1'b0;
    repeat (l) @(negedge clock);
  endtask
  task automatic send_bit(input logic b);
    if (b) pulse(35, 28);
    else pulse(18, 45);
  endtask
  task automatic send_word(input logic [23:0] wd, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(wd[i]);
  endtask
  task automatic idle_low(input int n);
    neo_in = 1'b0;
    repeat (n) @(negedge clock);
  endtask
  int v0, e0, t25, nbadw;
  logic [23:0] fw;
  logic [23:0] pat;
  initial begin
    repeat (3) @(negedge clock);
    check("rst_neo_out", 32'(neo_out), 32'd0);
    check("rst_pixel_data", 32'(pixel_data), 32'h0);
    check("rst_valid", 32'(pixel_valid), 32'd0);
    check("rst_error", 32'(frame_error), 32'd0);
    reset = 1'b0;
    idle_low(10);
    v0 = nvalid; e0 = nerr;
    send_word(24'hA53CF0, 24);
    idle_low(2600);
    check("single_valid_cnt", 32'(nvalid - v0), 32'd1);
    check("single_err_cnt", 32'(nerr - e0), 32'd0);
    check("single_data", 32'(pixel_data), 32'hA53CF0);
    check("single_no_fwd", 32'(ws.size()), 32'd0);
    v0 = nvalid; e0 = nerr;
    send_word(24'h112233, 24);
    t25 = cyc;
    send_word(24'h445566, 24);
    idle_low(2600);
    check("chain_valid_cnt", 32'(nvalid - v0), 32'd1);
    check("chain_err_cnt", 32'(nerr - e0), 32'd0);
    check("chain_data", 32'(pixel_data), 32'h112233);
    check("chain_fwd_pulses", 32'(ws.size()), 32'd24);
    fw = '0; nbadw = 0;
    foreach (ws[i]) begin
      fw = {fw[22:0], ws[i] > 26};
      if (!((ws[i] >= 17 && ws[i] <= 19) || (ws[i] >= 34 && ws[i] <= 36))) nbadw++;
    end
    check("chain_fwd_word", 32'(fw), 32'h445566);
    check("chain_fwd_widths", 32'(nbadw), 32'd0);
    check("chain_fwd_lag", 32'(first_rise - t25), 32'd3);
    v0 = nvalid; e0 = nerr;
    send_word(24'hABC000, 10);
    idle_low(2600);
    check("short_err_cnt", 32'(nerr - e0), 32'd1);
    check("short_valid_cnt", 32'(nvalid - v0), 32'd0);
    check("short_data_hold", 32'(pixel_data), 32'h112233);
    v0 = nvalid; e0 = nerr;
    t25 = cyc;
    pulse(100, 1000);
    check("err_pulse_cnt", 32'(nerr - e0), 32'd1);
    check("err_at_hcnt60", 32'(fe_cyc - t25), 32'd62);
    send_word(24'h00FF00, 24);
    idle_low(2600);
    check("err_frame_ignored", 32'(nvalid - v0), 32'd0);
    send_word(24'h00FF00, 24);
    idle_low(2600);
    check("err_recover_valid", 32'(nvalid - v0), 32'd1);
    check("err_recover_data", 32'(pixel_data), 32'h00FF00);
    check("err_single_pulse", 32'(nerr - e0), 32'd1);
    v0 = nvalid; e0 = nerr;
    pat = 24'h2B3C4D;
    pulse(26, 37);
    pulse(27, 36);
    pulse(3, 20);
    for (int i = 21; i >= 0; i--) send_bit(pat[i]);
    idle_low(2600);
    check("glitch_valid_cnt", 32'(nvalid - v0), 32'd1);
    check("glitch_err_cnt", 32'(nerr - e0), 32'd0);
    check("glitch_bound_data", 32'(pixel_data), 32'h6B3C4D);
    v0 = nvalid; e0 = nerr;
    send_word(24'h0F0F0F, 12);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("midrst_data_clear", 32'(pixel_data), 32'h0);
    reset = 1'b0;
    idle_low(5);
    check("midrst_no_pulse", 32'(nvalid - v0 + nerr - e0), 32'd0);
    send_word(24'hFFFFFF, 24);
    idle_low(2600);
    check("midrst_valid_cnt", 32'(nvalid - v0), 32'd1);
    check("midrst_err_cnt", 32'(nerr - e0), 32'd0);
    check("midrst_data", 32'(pixel_data), 32'hFFFFFF);
    check("never_both", 32'(nboth), 32'd0);
    check("data_only_on_valid", 32'(nbadchg), 32'd0);
    check("fwd_total", 32'(ws.size()), 32'd24);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
